parking_gate_ctrl: RTL

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/parking_gate_ctrl.sv
// Six-slot parking gate sequencer: arbitrates entry/exit requests and drives the check-in/out datapath.
// Optional fee ceiling: define PARK_FEE_CAP_EN to clamp out_fee at FEE_CAP.
module parking_gate_ctrl #(
  parameter int unsigned WAIT_CYC = 2,
  parameter logic [10:0] FEE_CAP  = 11'd500
) (
  input  logic        clk,
  input  logic        firstInteract,
  input  logic        in_req,
  input  logic        out_req,
  input  logic [3:0]  out_slot,
  input  logic [10:0] dp_fee,
  output logic [3:0]  dp_selector,
  output logic        dp_free,
  output logic        dp_strobe,
  output logic        in_ack,
  output logic [3:0]  in_slot,
  output logic        out_ack,
  output logic        out_err,
  output logic [10:0] out_fee,
  output logic [5:0]  occupancy,
  output logic [2:0]  count,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_STROBE, S_WAIT, S_ACK} state_t;

  state_t      state_q, state_d;
  logic        rr_in_q, rr_in_d;   // 1: entry wins the next tie
  logic        exit_q, exit_d;
  logic        ok_q, ok_d;
  logic [3:0]  sel_q, sel_d;
  logic        free_q, free_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [5:0]  occ_q, occ_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        in_ack_q, in_ack_d;
  logic [3:0]  in_slot_q, in_slot_d;
  logic        out_ack_q, out_ack_d;
  logic        out_err_q, out_err_d;
  logic [10:0] out_fee_q, out_fee_d;

  logic [3:0]  low_free;
  logic        full;
  logic        exit_valid;
  logic        grant_exit;
  logic [10:0] fee_capped;

`ifdef PARK_FEE_CAP_EN
  assign fee_capped = (dp_fee > FEE_CAP) ? FEE_CAP : dp_fee;
`else
  logic unused_fee_cap;
  assign unused_fee_cap = ^FEE_CAP;
  assign fee_capped     = dp_fee;
`endif

  function automatic logic [2:0] popcnt6(input logic [5:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < 6; i++) p = p + {2'b00, v[i]};
    return p;
  endfunction

  always_comb begin
    low_free = 4'd0;
    for (int k = 6; k >= 1; k--) begin
      if (!occ_q[k-1]) low_free = 4'(k);
    end
  end

  assign full       = &occ_q;
  assign exit_valid = (out_slot >= 4'd1) && (out_slot <= 4'd6) && occ_q[3'(out_slot - 4'd1)];
  assign grant_exit = out_req && (!in_req || !rr_in_q);

  always_comb begin
    state_d   = state_q;
    rr_in_d   = rr_in_q;
    exit_d    = exit_q;
    ok_d      = ok_q;
    sel_d     = sel_q;
    free_d    = free_q;
    wcnt_d    = wcnt_q;
    occ_d     = occ_q;
    cnt_d     = cnt_q;
    in_ack_d  = 1'b0;
    in_slot_d = in_slot_q;
    out_ack_d = 1'b0;
    out_err_d = out_err_q;
    out_fee_d = out_fee_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_req || out_req) begin
          rr_in_d = grant_exit;
          exit_d  = grant_exit;
          if (grant_exit) begin
            ok_d    = exit_valid;
            sel_d   = exit_valid ? out_slot : 4'd0;
            free_d  = 1'b0;
            state_d = exit_valid ? S_ISSUE : S_ACK;
          end else begin
            ok_d    = !full;
            sel_d   = full ? 4'd0 : low_free;
            free_d  = !full;
            state_d = full ? S_ACK : S_ISSUE;
          end
        end
      end
      S_ISSUE: state_d = S_STROBE;
      S_STROBE: begin
        wcnt_d  = 4'(WAIT_CYC - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) state_d = S_ACK;
        else                wcnt_d  = wcnt_q - 4'd1;
      end
      S_ACK: begin
        state_d = S_IDLE;
        sel_d   = 4'd0;
        free_d  = 1'b0;
        if (exit_q) begin
          out_ack_d = 1'b1;
          out_err_d = !ok_q;
          out_fee_d = ok_q ? fee_capped : 11'd0;
          if (ok_q) occ_d[3'(sel_q - 4'd1)] = 1'b0;
        end else begin
          in_ack_d  = 1'b1;
          in_slot_d = sel_q;
          if (ok_q) occ_d[3'(sel_q - 4'd1)] = 1'b1;
        end
        cnt_d = popcnt6(occ_d);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge firstInteract) begin
    if (firstInteract) begin
      state_q   <= S_IDLE;
      rr_in_q   <= 1'b0;
      exit_q    <= 1'b0;
      ok_q      <= 1'b0;
      sel_q     <= 4'd0;
      free_q    <= 1'b0;
      wcnt_q    <= 4'd0;
      occ_q     <= 6'd0;
      cnt_q     <= 3'd0;
      in_ack_q  <= 1'b0;
      in_slot_q <= 4'd0;
      out_ack_q <= 1'b0;
      out_err_q <= 1'b0;
      out_fee_q <= 11'd0;
    end else begin
      state_q   <= state_d;
      rr_in_q   <= rr_in_d;
      exit_q    <= exit_d;
      ok_q      <= ok_d;
      sel_q     <= sel_d;
      free_q    <= free_d;
      wcnt_q    <= wcnt_d;
      occ_q     <= occ_d;
      cnt_q     <= cnt_d;
      in_ack_q  <= in_ack_d;
      in_slot_q <= in_slot_d;
      out_ack_q <= out_ack_d;
      out_err_q <= out_err_d;
      out_fee_q <= out_fee_d;
    end
  end

  assign dp_selector = sel_q;
  assign dp_free     = free_q;
  assign dp_strobe   = (state_q == S_STROBE);
  assign busy        = (state_q != S_IDLE);
  assign in_ack      = in_ack_q;
  assign in_slot     = in_slot_q;
  assign out_ack     = out_ack_q;
  assign out_err     = out_err_q;
  assign out_fee     = out_fee_q;
  assign occupancy   = occ_q;
  assign count       = cnt_q;

endmodule
